// File: rtl/fir_seq_pkg.sv
// rtl/fir_seq_pkg.sv - shared state enum and coefficient codes for the FIR sequencer
package fir_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } seq_state_t;

  localparam logic [1:0] COEF_ZERO = 2'b00;
  localparam logic [1:0] COEF_POS  = 2'b01;
  localparam logic [1:0] COEF_NEG  = 2'b11;
  localparam logic [1:0] COEF_ILL  = 2'b10;

  // Maps the one illegal code onto zero so the FIR never sees it.
  function automatic logic [1:0] coef_sanitize(input logic [1:0] code);
    case (code)
      COEF_POS:  return COEF_POS;
      COEF_NEG:  return COEF_NEG;
      COEF_ZERO: return COEF_ZERO;
      default:   return COEF_ZERO;
    endcase
  endfunction

  function automatic logic coef_is_ill(input logic [1:0] code);
    return code == COEF_ILL;
  endfunction

endpackage

// File: rtl/fir_valid_delay.sv
// rtl/fir_valid_delay.sv - DEPTH-stage bit shift register with synchronous clear
module fir_valid_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (clr) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/fir_coef_sequencer.sv
// rtl/fir_coef_sequencer.sv - loads, flushes and streams the ternary-coefficient FIR
// Optional macro FIR_SEQ_COEF_CHECK_EN: illegal codes are written as zero and flagged on coef_err.
module fir_coef_sequencer
  import fir_seq_pkg::*;
#(
  parameter int TAP_NUMBER   = 10,
  parameter int INPUT_LENTGH = 8,
  parameter int FIR_LAT      = 2
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             cfg_valid,
  output logic                                             cfg_ready,
  input  logic [2*TAP_NUMBER-1:0]                          cfg_coefs,
  input  logic                                             s_valid,
  output logic                                             s_ready,
  input  logic signed [INPUT_LENTGH-1:0]                   s_data,
  output logic signed [INPUT_LENTGH-1:0]                   fir_in,
  output logic [$clog2(TAP_NUMBER)-1:0]                    fir_coef_num,
  output logic signed [1:0]                                fir_coef_val,
  output logic                                             fir_coef_w_en,
  input  logic signed [$clog2(TAP_NUMBER)+INPUT_LENTGH+1:0] fir_out,
  output logic                                             m_valid,
  output logic signed [$clog2(TAP_NUMBER)+INPUT_LENTGH+1:0] m_data,
  output logic                                             busy,
  output logic                                             coef_err
);

  localparam int CW = $clog2(TAP_NUMBER);
  localparam int FW = $clog2(TAP_NUMBER + FIR_LAT);
  localparam logic [CW-1:0] LAST_TAP   = CW'(TAP_NUMBER - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(TAP_NUMBER + FIR_LAT - 1);

  function automatic logic [1:0] tap_code(input logic [2*TAP_NUMBER-1:0] set,
                                          input logic [CW-1:0]           idx);
    logic [1:0] code;
    code = COEF_ZERO;
    for (int j = 0; j < TAP_NUMBER; j++) begin
      if (idx == CW'(j)) code = set[2*j +: 2];
    end
    return code;
  endfunction

  function automatic logic [1:0] wr_code(input logic [1:0] code);
`ifdef FIR_SEQ_COEF_CHECK_EN
    return coef_sanitize(code);
`else
    return code;
`endif
  endfunction

  seq_state_t              state;
  logic [2*TAP_NUMBER-1:0] shadow;
  logic [FW-1:0]           flush_cnt;
  logic                    in_vld;
  logic                    vld_tail;
  logic                    cfg_acc;
  logic                    s_acc;
  logic [CW-1:0]           next_num;
  logic [1:0]              next_code;

  assign cfg_ready = (state == IDLE) || (state == RUN);
  assign s_ready   = (state == RUN) && !cfg_valid;
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign s_acc     = s_valid && s_ready;
  assign next_num  = fir_coef_num + CW'(1);
  assign next_code = tap_code(shadow, next_num);

  // fir_in is registered so the sample and its accept bit enter the FIR timeline together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      shadow        <= '0;
      flush_cnt     <= '0;
      fir_in        <= '0;
      in_vld        <= 1'b0;
      fir_coef_num  <= '0;
      fir_coef_val  <= '0;
      fir_coef_w_en <= 1'b0;
      busy          <= 1'b0;
    end else begin
      fir_in <= '0;
      in_vld <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (cfg_acc) begin
            state         <= LOAD;
            shadow        <= cfg_coefs;
            fir_coef_num  <= '0;
            fir_coef_val  <= wr_code(cfg_coefs[1:0]);
            fir_coef_w_en <= 1'b1;
            busy          <= 1'b1;
          end else if (s_acc) begin
            fir_in <= s_data;
            in_vld <= 1'b1;
          end
        end
        LOAD: begin
          if (fir_coef_num == LAST_TAP) begin
            state         <= FLUSH;
            fir_coef_num  <= '0;
            fir_coef_val  <= '0;
            fir_coef_w_en <= 1'b0;
            flush_cnt     <= '0;
          end else begin
            fir_coef_num <= next_num;
            fir_coef_val <= wr_code(next_code);
          end
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state <= RUN;
            busy  <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fir_valid_delay #(
    .DEPTH(FIR_LAT)
  ) u_valid_delay (
    .clk(clk),
    .rst(rst),
    .clr(cfg_acc),
    .d  (in_vld),
    .q  (vld_tail)
  );

  // A reload suppresses every result still in flight, including one due on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      m_valid <= vld_tail && !cfg_acc;
      m_data  <= fir_out;
    end
  end

`ifdef FIR_SEQ_COEF_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coef_err <= 1'b0;
    end else if (cfg_acc) begin
      coef_err <= coef_is_ill(cfg_coefs[1:0]);
    end else if (state == LOAD && fir_coef_num != LAST_TAP && coef_is_ill(next_code)) begin
      coef_err <= 1'b1;
    end
  end
`else
  assign coef_err = 1'b0;
`endif

endmodule

// File: tb/tb_fir_coef_sequencer.sv
// tb/tb_fir_coef_sequencer.sv - self-checking bench for fir_coef_sequencer with an attached FIR model
module tb_fir_coef_sequencer;

  localparam int TAP     = 10;
  localparam int LAT     = 2;
  localparam int IW      = 8;
  localparam int CW      = 4;
  localparam int OW      = CW + IW + 2;
  localparam int RUN_OFS = 2*TAP + LAT;

  logic                 clk;
  logic                 rst;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [2*TAP-1:0]     cfg_coefs;
  logic                 s_valid;
  logic                 s_ready;
  logic signed [IW-1:0] s_data;
  logic signed [IW-1:0] fir_in;
  logic [CW-1:0]        fir_coef_num;
  logic signed [1:0]    fir_coef_val;
  logic                 fir_coef_w_en;
  logic signed [OW-1:0] fir_out;
  logic                 m_valid;
  logic signed [OW-1:0] m_data;
  logic                 busy;
  logic                 coef_err;

  fir_coef_sequencer #(
    .TAP_NUMBER(TAP),
    .INPUT_LENTGH(IW),
    .FIR_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_coefs(cfg_coefs),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .fir_in(fir_in), .fir_coef_num(fir_coef_num), .fir_coef_val(fir_coef_val),
    .fir_coef_w_en(fir_coef_w_en), .fir_out(fir_out),
    .m_valid(m_valid), .m_data(m_data), .busy(busy), .coef_err(coef_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int E = 0;

  always @(posedge clk) E <= E + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d edge=%0d", name, act, exp, E);
    end
  endtask

  // Attached FIR: input flop, delay line, output flop; taps written through the control pins.
  int fx[TAP];
  int fc[TAP];
  int facc;
  initial begin
    for (int i = 0; i < TAP; i++) begin
      fx[i] = 0;
      fc[i] = 0;
    end
    fir_out = '0;
  end
  always @(posedge clk) begin
    facc = 0;
    for (int i = 0; i < TAP; i++) facc += fc[i] * fx[i];
    fir_out <= facc[OW-1:0];
    for (int i = TAP-1; i > 0; i--) fx[i] = fx[i-1];
    fx[0] = int'(fir_in);
    if (fir_coef_w_en) fc[fir_coef_num] = int'(fir_coef_val);
  end

  // Reference model: schedule from acceptance edge, zero-stuffed sample window, due-edge result queue.
  typedef struct { int due; int val; } exp_t;
  exp_t expq[$];
  int   cap[$];
  int   win[TAP];
  int   raw[TAP];
  int   mc[TAP];
  int   cfg_t = -1;
  int   first_ill = -1;
  int   exp_in = 0;
  int   wen_cnt = 0;
  int   val3 = -1;
  bit   busy_e, run_e, wen_e;
  int   code_e, err_e, sum;

  always @(negedge clk) begin
    if (rst) begin
      cfg_t = -1;
      first_ill = -1;
      exp_in = 0;
      expq.delete();
      for (int i = 0; i < TAP; i++) win[i] = 0;
    end else begin
      busy_e = (cfg_t >= 0) && (E >= cfg_t) && (E < cfg_t + RUN_OFS);
      run_e  = (cfg_t >= 0) && (E >= cfg_t + RUN_OFS);
      wen_e  = (cfg_t >= 0) && (E >= cfg_t) && (E < cfg_t + TAP);
      code_e = 0;
      if (wen_e) begin
        code_e = raw[E - cfg_t];
`ifdef FIR_SEQ_COEF_CHECK_EN
        if (code_e == 2) code_e = 0;
`endif
      end
      err_e = 0;
`ifdef FIR_SEQ_COEF_CHECK_EN
      err_e = (cfg_t >= 0 && first_ill >= 0 && E >= cfg_t + first_ill) ? 1 : 0;
`endif
      chk("busy", busy, busy_e);
      chk("cfg_ready", cfg_ready, !busy_e);
      chk("s_ready", s_ready, run_e && !cfg_valid);
      chk("coef_w_en", fir_coef_w_en, wen_e);
      chk("coef_num", int'(fir_coef_num), wen_e ? E - cfg_t : 0);
      chk("coef_val", int'($unsigned(fir_coef_val)), code_e);
      chk("fir_in", int'(fir_in), exp_in);
      chk("coef_err", coef_err, err_e);
      if (expq.size() > 0 && expq[0].due == E) begin
        chk("m_valid", m_valid, 1);
        chk("m_data", int'(m_data), expq[0].val);
        void'(expq.pop_front());
      end else begin
        chk("m_valid", m_valid, 0);
      end
      if (fir_coef_w_en) wen_cnt++;
      if (fir_coef_w_en && fir_coef_num == 4'd3) val3 = int'($unsigned(fir_coef_val));
      if (m_valid) cap.push_back(int'(m_data));

      // What the coming edge does
      if (cfg_valid && !busy_e) begin
        cfg_t = E + 1;
        first_ill = -1;
        for (int i = 0; i < TAP; i++) begin
          raw[i] = int'(cfg_coefs[2*i +: 2]);
          case (raw[i])
            1: mc[i] = 1;
            3: mc[i] = -1;
            2: begin
`ifdef FIR_SEQ_COEF_CHECK_EN
              mc[i] = 0;
`else
              mc[i] = -2;
`endif
              if (first_ill < 0) first_ill = i;
            end
            default: mc[i] = 0;
          endcase
          win[i] = 0;
        end
        while (expq.size() > 0 && expq[$].due >= E + 1) void'(expq.pop_back());
        exp_in = 0;
      end else begin
        for (int i = TAP-1; i > 0; i--) win[i] = win[i-1];
        if (s_valid && run_e) begin
          win[0] = int'(s_data);
          sum = 0;
          for (int i = 0; i < TAP; i++) sum += mc[i] * win[i];
          expq.push_back('{due: E + 1 + LAT + 1, val: sum});
          exp_in = int'(s_data);
        end else begin
          win[0] = 0;
          exp_in = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [2*TAP-1:0] c, output int t);
    cfg_coefs = c;
    cfg_valid = 1'b1;
    t = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cfg_ready) begin
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        t = E;
        break;
      end
    end
    if (t < 0) chk("cfg_accept_timeout", 0, 1);
  endtask

  task automatic wait_run(input int t, output int lat);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_ready) begin
        lat = E - t;
        break;
      end
    end
    if (lat < 0) chk("run_timeout", 0, 1);
    tick(1);
  endtask

  task automatic put_sample(input int v);
    bit done;
    done = 1'b0;
    s_valid = 1'b1;
    s_data = IW'(v);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_ready) begin
        tick(1);
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("sample_timeout", 0, 1);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_cfg_ready"}, cfg_ready, 1);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_fir_in"}, int'(fir_in), 0);
    chk({tag, "_coef_num"}, int'(fir_coef_num), 0);
    chk({tag, "_coef_val"}, int'(fir_coef_val), 0);
    chk({tag, "_w_en"}, fir_coef_w_en, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, int'(m_data), 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_coef_err"}, coef_err, 0);
  endtask

  int t, lat;
  int exp2[12] = '{1, 3, 6, 10, 15, 21, 28, 36, 45, 55, 65, 75};
  int exp3[3]  = '{5, -5, 0};

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0;
    cfg_coefs = '0;
    s_valid = 1'b0;
    s_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    reset_check("rst");
    tick(1);
    rst = 1'b0;

    // Idle with samples offered but no configuration
    s_valid = 1'b1;
    s_data = 8'sd7;
    tick(20);
    s_valid = 1'b0;

    // All +1 taps, ramp 1..12
    wen_cnt = 0;
    do_cfg(20'h55555, t);
    wait_run(t, lat);
    chk("t2_latency", lat, 22);
    chk("t2_wen_cycles", wen_cnt, 10);
    cap.delete();
    for (int v = 1; v <= 12; v++) put_sample(v);
    s_valid = 1'b0;
    tick(10);
    chk("t2_count", cap.size(), 12);
    for (int i = 0; i < 12; i++) chk("t2_m_data", (i < cap.size()) ? cap[i] : -9999, exp2[i]);

    // +1,-1 impulse response
    wen_cnt = 0;
    do_cfg(20'h0000D, t);
    wait_run(t, lat);
    chk("t3_wen_cycles", wen_cnt, 10);
    cap.delete();
    put_sample(5);
    put_sample(0);
    put_sample(0);
    s_valid = 1'b0;
    tick(10);
    chk("t3_count", cap.size(), 3);
    for (int i = 0; i < 3; i++) chk("t3_m_data", (i < cap.size()) ? cap[i] : -9999, exp3[i]);

    // Three-cycle bubble with tap0 only
    do_cfg(20'h00001, t);
    wait_run(t, lat);
    cap.delete();
    for (int v = 1; v <= 4; v++) put_sample(v);
    s_valid = 1'b0;
    tick(3);
    for (int v = 5; v <= 8; v++) put_sample(v);
    s_valid = 1'b0;
    tick(10);
    chk("t4_count", cap.size(), 8);
    for (int i = 0; i < 8; i++) chk("t4_m_data", (i < cap.size()) ? cap[i] : -9999, i + 1);

    // Configuration and sample offered together while results are in flight
    cap.delete();
    put_sample(10);
    put_sample(11);
    s_data = 8'sd99;
    do_cfg(20'h00001, t);
    s_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("t5_busy", busy, 1);
    wait_run(t, lat);
    tick(5);
    chk("t5_flushed_count", cap.size(), 0);
    put_sample(3);
    s_valid = 1'b0;
    tick(6);
    chk("t5_after_count", cap.size(), 1);
    chk("t5_after_data", (cap.size() > 0) ? cap[0] : -9999, 3);

    // Illegal code on tap 3, then a legal reload
    val3 = -1;
    do_cfg(20'h00081, t);
    wait_run(t, lat);
`ifdef FIR_SEQ_COEF_CHECK_EN
    chk("t6_tap3_val", val3, 0);
    chk("t6_coef_err", coef_err, 1);
`else
    chk("t6_tap3_val", val3, 2);
    chk("t6_coef_err", coef_err, 0);
`endif
    do_cfg(20'h00001, t);
    @(negedge clk);
    #1;
    chk("t6_err_cleared", coef_err, 0);
    wait_run(t, lat);

    // Reset in the middle of FLUSH
    do_cfg(20'h55555, t);
    tick(14);
    @(negedge clk);
    #1;
    chk("t7_busy_flush", busy, 1);
    tick(1);
    rst = 1'b1;
    #2;
    reset_check("t7");
    tick(1);
    rst = 1'b0;
    s_valid = 1'b1;
    s_data = 8'sd4;
    tick(30);
    s_valid = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
